prf_trigger_gen: RTL and testbench
==================================

Name: prf_trigger_gen

Overview:
- Radar timing source that drives the STC chain.
- Produces the PRF trigger pulse, a per-sample strobe and the range-bin index that the STC stage and downstream video path consume.
- Supports continuous or single-shot operation and an optional 4-step PRF stagger.
- Runs on the 50 MHz system clock.

Parameters:
- SAMPLE_DIV, 2, clocks per range sample (sample_stb period); must be >= 2.
- RANGE_BINS, 2627, sample strobes per PRI (bins 0..2626).
- TRIG_WIDTH, 4, trig pulse width in clocks; must be >= 1.
- PRI_CLKS, 50000, base PRI in clocks (1 kHz PRF).
- STAG_STEP, 500, stagger increment in clocks.
- CNT_W, 16, period counter width; must hold PRI_CLKS + 3*STAG_STEP.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  continuous triggering request; level-sensitive.
- single_shot  in  1  one-PRI request; 1-cycle pulse.
- stagger_en  in  1  enables PRF stagger.
- trig  out  1  PRF trigger pulse.
- sample_stb  out  1  1-cycle range sample strobe.
- range_bin  out  12  index of current/last sample strobe.
- last_bin  out  1  high with the final strobe of a PRI.
- pri_idx  out  2  stagger slot of current PRI.
- busy  out  1  high from first trig cycle to end of PRI.

Behaviour:
- Reset:
  - trig, sample_stb, last_bin, busy, range_bin, pri_idx, period counter and divider are 0.
  - State is IDLE.
  - rst mid-PRI aborts immediately with no completion.
- States: IDLE, TRIG, LISTEN, DEAD.
- IDLE:
  - Leaves when enable=1 or single_shot=1; goes to TRIG next cycle (1-cycle latency).
  - Both set in the same cycle: treated as enable.
- Period latch:
  - On entry to TRIG, period = PRI_CLKS + (stagger_en ? pri_idx*STAG_STEP : 0).
  - period_cnt = 0 on the first trig cycle; increments every clock while busy.
- TRIG:
  - trig=1 for exactly TRIG_WIDTH cycles (period_cnt 0..TRIG_WIDTH-1).
  - range_bin cleared to 0 on the first cycle.
- LISTEN:
  - sample_stb=1 when period_cnt = TRIG_WIDTH + k*SAMPLE_DIV + SAMPLE_DIV-1, for k = 0..RANGE_BINS-1.
  - range_bin=k on that cycle and holds between strobes.
  - Strobe k=RANGE_BINS-1 also asserts last_bin; state goes to DEAD next cycle.
- DEAD:
  - Waits until period_cnt = period-1.
  - Next state is TRIG if enable=1 sampled on that cycle, else IDLE (busy drops).
  - Consecutive trig rising edges are exactly period clocks apart.
- pri_idx:
  - Increments mod 4 on each TRIG entry after the first while stagger_en=1.
  - Forced to 0 whenever stagger_en=0 at TRIG entry.
  - stagger_en changes mid-PRI take effect only at the next TRIG entry.
- enable deassert mid-PRI: current PRI completes (all RANGE_BINS strobes and dead time), then IDLE.
- single_shot while busy: ignored, not queued.
- Configuration legality: TRIG_WIDTH + RANGE_BINS*SAMPLE_DIV < PRI_CLKS is an elaboration-time check that fails elaboration if violated.
- Arithmetic:
  - The period comparison uses CNT_W-bit unsigned arithmetic.
  - range_bin is 12-bit unsigned and never wraps, since RANGE_BINS <= 4096 is checked.

Decomposition:
- Shared package stc_pkg holds:
  - State enum (IDLE/TRIG/LISTEN/DEAD).
  - RANGE_W=12.
  - The 2627-bin default, also consumed by the STC block for its sample limit.
- One natural sub-module, sample_strobe_div:
  - Modulo-SAMPLE_DIV counter with synchronous clear and enable.
  - Outputs the 1-cycle strobe.

Test Plan:
- Reset: assert rst mid-LISTEN -> all outputs 0 in the same cycle; after release with enable=1, trig rises 1 cycle later and range_bin restarts at 0.
- Continuous, stagger off, enable=1 at cycle 0:
  - trig high cycles 1..4.
  - First sample_stb at cycle 6 with range_bin=0.
  - Last strobe at cycle 5258 with range_bin=2626 and last_bin=1.
  - Exactly 2627 strobes per PRI.
  - Next trig rising edge at cycle 50001.
- Stagger on: trig rising-edge spacings 50000, 50500, 51000, 51500, 50000; pri_idx 0,1,2,3,0.
- enable drops during LISTEN (bin 1000) -> strobes continue to 2626; no further trig; busy falls at period end; state IDLE.
- single_shot pulse in IDLE:
  - Exactly one PRI of 2627 strobes, then IDLE.
  - A second single_shot during that PRI produces no extra trig.
- stagger_en toggled 1->0 mid-PRI with pri_idx=2 -> current PRI keeps 51000 clocks; next PRI uses 50000 with pri_idx=0.

Source files
------------

// File: rtl/stc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stc_pkg
// Description : Shared constants for the radar timing / STC chain.
// Revision    : 1.0 - initial release
// ============================================================================
package stc_pkg;

    localparam int c_RANGE_W        = 12;
    // Default bin count, also used by the STC block as its sample limit.
    localparam int c_DEF_RANGE_BINS = 2627;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_TRIG   = 2'd1;
    localparam logic [1:0] c_ST_LISTEN = 2'd2;
    localparam logic [1:0] c_ST_DEAD   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sample_strobe_div.sv
`default_nettype none
// ============================================================================
// Module      : sample_strobe_div
// Description : Modulo-SAMPLE_DIV counter producing a 1-cycle range strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_strobe_div #(
    parameter int SAMPLE_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_stb
);

    localparam int                 c_DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_LAST  = c_DIV_W'(SAMPLE_DIV - 1);

    logic [c_DIV_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_stb = i_en && !i_clr && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/prf_trigger_gen.sv
`default_nettype none
// ============================================================================
// Module      : prf_trigger_gen
// Description : PRF trigger, range-sample strobe and range-bin index source.
// Revision    : 1.0 - initial release
// ============================================================================
module prf_trigger_gen
    import stc_pkg::*;
#(
    parameter int SAMPLE_DIV = 2,
    parameter int RANGE_BINS = c_DEF_RANGE_BINS,
    parameter int TRIG_WIDTH = 4,
    parameter int PRI_CLKS   = 50000,
    parameter int STAG_STEP  = 500,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 single_shot,
    input  logic                 stagger_en,
    output logic                 trig,
    output logic                 sample_stb,
    output logic [c_RANGE_W-1:0] range_bin,
    output logic                 last_bin,
    output logic [1:0]           pri_idx,
    output logic                 busy
);

    generate
        if (TRIG_WIDTH + RANGE_BINS * SAMPLE_DIV >= PRI_CLKS) begin : g_bad_timing
            $error("prf_trigger_gen: trigger plus listen window does not fit in PRI_CLKS");
        end
        if (SAMPLE_DIV < 2 || TRIG_WIDTH < 1 || RANGE_BINS < 1 || RANGE_BINS > 4096) begin : g_bad_shape
            $error("prf_trigger_gen: illegal SAMPLE_DIV, TRIG_WIDTH or RANGE_BINS");
        end
        if ((longint'(PRI_CLKS) + 3 * longint'(STAG_STEP)) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
            $error("prf_trigger_gen: CNT_W too narrow for the longest staggered PRI");
        end
    endgenerate

    localparam logic [CNT_W-1:0]     c_PRI      = CNT_W'(PRI_CLKS);
    localparam logic [CNT_W-1:0]     c_STEP     = CNT_W'(STAG_STEP);
    localparam logic [CNT_W-1:0]     c_TW_LAST  = CNT_W'(TRIG_WIDTH - 1);
    localparam logic [c_RANGE_W-1:0] c_LAST_BIN = c_RANGE_W'(RANGE_BINS - 1);

    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_periodCnt;
    logic [CNT_W-1:0]     r_period;
    logic                 r_trig;
    logic                 r_sampleStb;
    logic                 r_lastBin;
    logic                 r_busy;
    logic [c_RANGE_W-1:0] r_rangeBin;
    logic [1:0]           r_priIdx;
    logic                 r_firstEntry;
    logic                 r_firstStb;

    logic                 w_divEn;
    logic                 w_divStb;
    logic                 w_periodEnd;
    logic                 w_start;
    logic [1:0]           w_nextIdx;
    logic [CNT_W-1:0]     w_nextPeriod;
    logic [c_RANGE_W-1:0] w_nextBin;

    always_comb begin
        w_periodEnd = (r_state == c_ST_DEAD) && (r_periodCnt == r_period - 1'b1);
        w_start     = ((r_state == c_ST_IDLE) && (enable || single_shot)) ||
                      (w_periodEnd && enable);
        if (!stagger_en) begin
            w_nextIdx = '0;
        end else if (r_firstEntry) begin
            w_nextIdx = r_priIdx;
        end else begin
            w_nextIdx = r_priIdx + 1'b1;
        end
        w_nextPeriod = c_PRI + (stagger_en ? CNT_W'(w_nextIdx) * c_STEP : '0);
        w_nextBin    = r_firstStb ? '0 : r_rangeBin + 1'b1;
        // Divider starts on the last trig cycle so its strobe leads the registered one by a clock.
        w_divEn      = (r_state == c_ST_LISTEN) ||
                       ((r_state == c_ST_TRIG) && (r_periodCnt == c_TW_LAST));
    end

    sample_strobe_div #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .i_clr (!w_divEn),
        .i_en  (w_divEn),
        .o_stb (w_divStb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_periodCnt  <= '0;
            r_period     <= '0;
            r_trig       <= 1'b0;
            r_sampleStb  <= 1'b0;
            r_lastBin    <= 1'b0;
            r_busy       <= 1'b0;
            r_rangeBin   <= '0;
            r_priIdx     <= '0;
            r_firstEntry <= 1'b1;
            r_firstStb   <= 1'b0;
        end else begin
            r_sampleStb <= w_divStb;
            if (w_divStb) begin
                r_rangeBin <= w_nextBin;
                r_lastBin  <= (w_nextBin == c_LAST_BIN);
                r_firstStb <= 1'b0;
            end else begin
                r_lastBin  <= 1'b0;
            end
            if (r_busy) begin
                r_periodCnt <= r_periodCnt + 1'b1;
            end

            if (w_start) begin
                r_state      <= c_ST_TRIG;
                r_trig       <= 1'b1;
                r_busy       <= 1'b1;
                r_periodCnt  <= '0;
                r_period     <= w_nextPeriod;
                r_priIdx     <= w_nextIdx;
                r_firstEntry <= 1'b0;
                r_rangeBin   <= '0;
                r_firstStb   <= 1'b1;
            end else begin
                case (r_state)
                    c_ST_TRIG: begin
                        if (r_periodCnt == c_TW_LAST) begin
                            r_trig  <= 1'b0;
                            r_state <= c_ST_LISTEN;
                        end
                    end
                    c_ST_LISTEN: begin
                        if (r_sampleStb && r_lastBin) begin
                            r_state <= c_ST_DEAD;
                        end
                    end
                    c_ST_DEAD: begin
                        if (w_periodEnd) begin
                            r_state <= c_ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign trig       = r_trig;
    assign sample_stb = r_sampleStb;
    assign range_bin  = r_rangeBin;
    assign last_bin   = r_lastBin;
    assign pri_idx    = r_priIdx;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_prf_trigger_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_prf_trigger_gen
// Description : Scoreboard bench for prf_trigger_gen with a PRI-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prf_trigger_gen;

    localparam int SD   = 3;
    localparam int RB   = 20;
    localparam int TW   = 4;
    localparam int PRI  = 120;
    localparam int STEP = 7;
    localparam int CW   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        single_shot = 1'b0;
    logic        stagger_en = 1'b0;
    logic        trig;
    logic        sample_stb;
    logic [11:0] range_bin;
    logic        last_bin;
    logic [1:0]  pri_idx;
    logic        busy;

    prf_trigger_gen #(
        .SAMPLE_DIV (SD),
        .RANGE_BINS (RB),
        .TRIG_WIDTH (TW),
        .PRI_CLKS   (PRI),
        .STAG_STEP  (STEP),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .single_shot (single_shot),
        .stagger_en  (stagger_en),
        .trig        (trig),
        .sample_stb  (sample_stb),
        .range_bin   (range_bin),
        .last_bin    (last_bin),
        .pri_idx     (pri_idx),
        .busy        (busy)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        int cyc;
        int bin;
        bit last;
        int idx;
    } ev_t;

    ev_t stbQ[$];
    ev_t trigQ[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;

    // Model: one PRI is a start cycle, a length, and a list of strobe times.
    bit  mActive = 0;
    bit  mFirst = 1;
    int  mIdx = 0;
    int  mStart = 0;
    int  mEnd = -1;
    int  mP = 0;
    bit  mWasBusy = 0;
    bit  mGo = 0;
    bit  expBusy = 0;
    bit  expTrig = 0;
    bit  prevTrig = 0;
    int  r = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(input string name, input int expCyc);
        checks++;
        errors++;
        $display("FAIL %s: event due at cycle %0d not seen (now cycle %0d)", name, expCyc, cyc);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                stbQ.delete();
                trigQ.delete();
                mActive = 0;
                mFirst  = 1;
                mIdx    = 0;
            end else begin
                mWasBusy = mActive && (cyc - 1 <= mEnd);
                mGo = mWasBusy ? ((cyc - 1 == mEnd) && enable) : (enable || single_shot);
                if (mGo) begin
                    if (!stagger_en) mIdx = 0;
                    else if (!mFirst) mIdx = (mIdx + 1) % 4;
                    mFirst  = 0;
                    mP      = PRI + (stagger_en ? mIdx * STEP : 0);
                    mActive = 1;
                    mStart  = cyc;
                    mEnd    = cyc + mP - 1;
                    trigQ.push_back('{cyc, 0, 1'b0, mIdx});
                    for (int k = 0; k < RB; k++)
                        stbQ.push_back('{cyc + TW + k * SD + SD - 1, k, (k == RB - 1), mIdx});
                end
            end
            expBusy = mActive && (cyc <= mEnd);
            expTrig = mActive && (cyc >= mStart) && (cyc < mStart + TW);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs", 32'({trig, sample_stb, last_bin, busy, range_bin, pri_idx}), 32'd0);
            end else begin
                chk("busy", 32'(busy), 32'(expBusy));
                chk("trig_level", 32'(trig), 32'(expTrig));
                chk("pri_idx", 32'(pri_idx), 32'(mIdx));
                while (stbQ.size() > 0 && stbQ[0].cyc < cyc) begin
                    failNow("strobe_missed", stbQ[0].cyc);
                    void'(stbQ.pop_front());
                end
                while (trigQ.size() > 0 && trigQ[0].cyc < cyc) begin
                    failNow("trig_missed", trigQ[0].cyc);
                    void'(trigQ.pop_front());
                end
                if (sample_stb) begin
                    if (stbQ.size() > 0 && stbQ[0].cyc == cyc) begin
                        chk("range_bin", 32'(range_bin), 32'(stbQ[0].bin));
                        chk("last_bin", 32'(last_bin), 32'(stbQ[0].last));
                        void'(stbQ.pop_front());
                    end else begin
                        chk("strobe_unexpected", 32'(sample_stb), 32'd0);
                    end
                end else begin
                    chk("last_bin_no_strobe", 32'(last_bin), 32'd0);
                end
                if (trig && !prevTrig) begin
                    if (trigQ.size() > 0 && trigQ[0].cyc == cyc) begin
                        chk("trig_rise_bin0", 32'(range_bin), 32'd0);
                        void'(trigQ.pop_front());
                    end else begin
                        chk("trig_unexpected", 32'(trig), 32'd0);
                    end
                end
            end
            prevTrig = trig && !rst;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulseSingle();
        single_shot = 1'b1;
        step(1);
        single_shot = 1'b0;
    endtask

    task automatic waitBin(input int bin);
        for (int i = 0; i < 2000 && !(busy && range_bin == 12'(bin)); i++) step(1);
        chk("wait_range_bin", 32'(range_bin), 32'(bin));
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(2);

        // Staggered continuous run through a full 4-slot cycle.
        stagger_en = 1'b1;
        enable     = 1'b1;
        step(4 * (PRI + 3 * STEP) + 40);
        for (int i = 0; i < 2000 && !(busy && pri_idx == 2'd2); i++) step(1);
        chk("wait_pri_idx2", 32'(pri_idx), 32'd2);
        step(30);
        stagger_en = 1'b0;
        step(2 * PRI + 20);
        enable = 1'b0;
        step(PRI + 40);

        // Plain continuous, then enable dropped mid-listen.
        enable = 1'b1;
        step(2 * PRI);
        waitBin(10);
        enable = 1'b0;
        step(PRI + 40);

        // Single shot, with a second request ignored while busy.
        pulseSingle();
        step(30);
        pulseSingle();
        step(PRI + 40);

        // Both requests together behave as continuous enable.
        enable = 1'b1;
        single_shot = 1'b1;
        step(1);
        single_shot = 1'b0;
        step(PRI + 10);

        // Reset in the middle of the listen window.
        waitBin(5);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(PRI + 50);
        enable = 1'b0;
        step(PRI + 40);

        repeat (40) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                rst = 1'b1;
                step(1 + int'($urandom_range(0, 2)));
                rst = 1'b0;
            end else if (r <= 3) begin
                pulseSingle();
            end else begin
                enable = 1'($urandom_range(0, 1));
            end
            stagger_en = ($urandom_range(0, 3) != 0);
            step(1 + int'($urandom_range(0, 250)));
        end

        enable      = 1'b0;
        single_shot = 1'b0;
        step(3 * PRI);
        chk("queues_drained", 32'(stbQ.size() + trigQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
